// File: rtl/timebase_timer.sv
// Timebase: divides clk to a single-cycle tick enable plus a 50% square wave,
// with run/pause and phase clear, and a loadable down-count timer in tick units.
// Everything runs on clk; tick is an enable pulse, never used as a clock.
module timebase_timer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned TMR_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_cancel,
    output logic             o_tick,
    output logic             o_sq_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [TMR_W-1:0] o_remain
);

    // Divider geometry; DIV is expected to be an even integer >= 2.
    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [TMR_W-1:0] REM_ONE  = TMR_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_pre_cnt;
    logic             r_tick;
    logic             r_sq;
    logic             w_pre_last;
    logic             w_pre_half;

    // Phase decode of the prescaler count.
    always_comb begin
        w_pre_last = (r_pre_cnt == CNT_LAST);
        w_pre_half = (r_pre_cnt == CNT_HALF);
    end

    // Prescaler count, tick pulse and square wave; clr beats en, pause holds phase.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
        end else if (i_clr) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
        end else if (i_en) begin
            r_pre_cnt <= w_pre_last ? '0 : r_pre_cnt + CNT_W'(1);
            r_tick    <= w_pre_last;
            if (w_pre_last || w_pre_half) begin
                r_sq <= ~r_sq;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_remain;
    logic [TMR_W-1:0] w_remain_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_load_nz;
    logic             w_last_tick;

    // Shared decodes: non-zero load, and a tick that consumes the final count.
    always_comb begin
        w_load_nz   = |i_load_val;
        w_last_tick = r_tick && (r_remain == REM_ONE);
    end

    // Timer state register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; priority cancel > start > tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_cancel && i_start && w_load_nz) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_start) begin
                    if (!w_load_nz) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_last_tick) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next remaining count and done pulse; a start always hides a coincident tick.
    always_comb begin
        w_remain_nxt = r_remain;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_cancel && i_start) begin
                    if (w_load_nz) begin
                        w_remain_nxt = i_load_val;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_cancel) begin
                    w_remain_nxt = '0;
                end else if (i_start) begin
                    if (w_load_nz) begin
                        w_remain_nxt = i_load_val;
                    end else begin
                        w_remain_nxt = '0;
                        w_done_nxt   = 1'b1;
                    end
                end else if (w_last_tick) begin
                    w_remain_nxt = '0;
                    w_done_nxt   = 1'b1;
                end else if (r_tick && (r_remain != '0)) begin
                    w_remain_nxt = r_remain - REM_ONE;
                end
            end
            default: begin
                w_remain_nxt = '0;
            end
        endcase
    end

    // Registered timer outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_remain <= '0;
            r_done   <= 1'b0;
        end else begin
            r_remain <= w_remain_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Output mapping; all driven straight from registers.
    assign o_tick   = r_tick;
    assign o_sq_out = r_sq;
    assign o_busy   = (r_state == ST_RUN);
    assign o_done   = r_done;
    assign o_remain = r_remain;

endmodule

// File: tb/tb_timebase_timer.sv
// Bench for timebase_timer: directed literal scenarios followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_timebase_timer;

    localparam int DIV = 10;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic       start;
    logic [7:0] load_val;
    logic       cancel;
    logic       tick;
    logic       sq_out;
    logic       busy;
    logic       done;
    logic [7:0] remain;

    timebase_timer #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .TMR_W  (8)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_en      (en),
        .i_clr     (clr),
        .i_start   (start),
        .i_load_val(load_val),
        .i_cancel  (cancel),
        .o_tick    (tick),
        .o_sq_out  (sq_out),
        .o_busy    (busy),
        .o_done    (done),
        .o_remain  (remain)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: enabled edges since last clear/reset, plus timer view.
    int m_n      = 0;
    bit m_tick   = 0;
    bit m_sq     = 0;
    bit m_busy   = 0;
    bit m_done   = 0;
    int m_remain = 0;
    bit m_valid  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Behavioural update for one rising edge from the inputs being presented.
    task automatic model_edge();
        bit t;
        t = m_tick;
        if (!reset) begin
            m_n = 0; m_tick = 0; m_sq = 0;
            m_busy = 0; m_done = 0; m_remain = 0;
            m_valid = 1;
        end else begin
            if (clr) begin
                m_n = 0; m_tick = 0; m_sq = 0;
            end else if (en) begin
                m_n++;
                m_tick = (m_n % DIV) == 0;
                m_sq   = ((m_n / (DIV / 2)) % 2) == 1;
            end else begin
                m_tick = 0;
            end
            m_done = 0;
            if (cancel) begin
                m_busy = 0; m_remain = 0;
            end else if (start) begin
                if (load_val == 0) begin
                    m_done = 1; m_busy = 0; m_remain = 0;
                end else begin
                    m_busy = 1; m_remain = int'(load_val);
                end
            end else if (m_busy && t) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        if (m_valid) begin
            chk("m_tick",   int'(tick),   int'(m_tick));
            chk("m_sq",     int'(sq_out), int'(m_sq));
            chk("m_busy",   int'(busy),   int'(m_busy));
            chk("m_done",   int'(done),   int'(m_done));
            chk("m_remain", int'(remain), m_remain);
        end
    endtask

    task automatic do_reset();
        reset = 0; en = 0; clr = 0; start = 0; cancel = 0; load_val = '0;
        step();
        step();
        chk("rst_tick", int'(tick), 0);
        chk("rst_sq",   int'(sq_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rem",  int'(remain), 0);
        reset = 1; en = 1;
        cyc = 0;
    endtask

    initial begin
        reset = 0; en = 0; clr = 0; start = 0; cancel = 0; load_val = '0;
        do_reset();

        // Free-running prescaler: ticks at 10,20,30; sq high in 5-9, 15-19...
        while (cyc < 35) begin
            step();
            chk("lit_tick", int'(tick), int'(cyc == 10 || cyc == 20 || cyc == 30));
            chk("lit_sq",   int'(sq_out), int'((cyc % 10) >= 5));
        end

        // Timer load 3: ticks at 40,50,60 -> remain 3,2,1, done in cycle 61.
        start = 1; load_val = 8'd3;
        step();
        start = 0;
        chk("lit_busy3", int'(busy), 1);
        chk("lit_rem3",  int'(remain), 3);
        while (cyc < 62) begin
            step();
            chk("lit_rem_seq", int'(remain), (cyc < 41) ? 3 : (cyc < 51) ? 2 : (cyc < 61) ? 1 : 0);
            chk("lit_busy_seq", int'(busy), int'(cyc < 61));
            chk("lit_done_seq", int'(done), int'(cyc == 61));
        end

        // Zero load: single done pulse, busy never set.
        start = 1; load_val = 8'd0;
        step();
        start = 0;
        chk("lit_done0", int'(done), 1);
        chk("lit_busy0", int'(busy), 0);
        step();
        chk("lit_done0_off", int'(done), 0);
        chk("lit_busy0_off", int'(busy), 0);

        // Reload coinciding with a tick at remain=2, then cancel.
        start = 1; load_val = 8'd3;
        step();
        start = 0;
        while (cyc < 80) step();
        chk("lit_rem_pre", int'(remain), 2);
        chk("lit_tick_80", int'(tick), 1);
        start = 1; load_val = 8'd5;
        step();
        start = 0;
        chk("lit_reload", int'(remain), 5);
        chk("lit_reload_busy", int'(busy), 1);
        while (cyc < 85) step();
        cancel = 1;
        step();
        cancel = 0;
        chk("lit_cancel_busy", int'(busy), 0);
        chk("lit_cancel_rem",  int'(remain), 0);
        while (cyc < 100) begin
            step();
            chk("lit_no_done", int'(done), 0);
        end

        // Pause for 7 cycles from cycle 3: first tick moves to 17.
        do_reset();
        while (cyc < 20) begin
            en = !(cyc >= 3 && cyc <= 9);
            step();
            chk("lit_pause_tick", int'(tick), int'(cyc == 17));
            if (cyc >= 4 && cyc <= 10) chk("lit_pause_sq", int'(sq_out), 0);
        end
        en = 1;

        // Mid-run reset while sq_out is high.
        start = 1; load_val = 8'd4;
        step();
        start = 0;
        while (cyc < 23) step();
        chk("lit_sq_hi", int'(sq_out), 1);
        chk("lit_run_busy", int'(busy), 1);
        reset = 0;
        step();
        reset = 1;
        chk("lit_mid_sq",   int'(sq_out), 0);
        chk("lit_mid_busy", int'(busy), 0);
        chk("lit_mid_rem",  int'(remain), 0);
        chk("lit_mid_tick", int'(tick), 0);
        while (cyc < 40) begin
            step();
            chk("lit_post_tick", int'(tick), int'(cyc == 34));
        end

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) != 0);
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 59) == 0);
            start    = ($urandom_range(0, 69) == 0);
            cancel   = ($urandom_range(0, 89) == 0);
            load_val = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
